// File: rtl/ref_row_fetcher.sv
// Fetches NUM_ROWS search-window rows (23 pixels, 184 b each) from a 64-bit word memory,
// three reads per row, and hands each row downstream over a valid/ready port.
module ref_row_fetcher #(
  parameter int ADDR_W     = 16,
  parameter int NUM_ROWS   = 23,
  parameter int ROW_STRIDE = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic [183:0]      row_data_o,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_OUT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;  // base + row*ROW_STRIDE, stepped per row
  logic [ROW_W-1:0]    row_q, row_d;
  logic [1:0]          word_q, word_d;
  logic [183:0]        data_q, data_d;
  logic                done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      row_addr_q <= '0;
      row_q      <= '0;
      word_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      row_q      <= row_d;
      word_q     <= word_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // Row port: a row transfers on any cycle where row_valid_o and row_ready_i are both high;
  // row_valid_o comes straight from state, so it never depends on row_ready_i in the same cycle.
  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    row_d      = row_q;
    word_d     = word_q;
    data_d     = data_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q marks the completion cycle, where a new start is still ignored
        if (start_i && !done_q) begin
          row_addr_d = base_addr_i;
          row_d      = '0;
          word_d     = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          case (word_q)
            2'd0:    data_d[63:0]    = mem_rdata_i;
            2'd1:    data_d[127:64]  = mem_rdata_i;
            default: data_d[183:128] = mem_rdata_i[55:0];
          endcase
          if (word_q == 2'd2) begin
            state_d = ST_OUT;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = ST_REQ;
          end
        end
      end
      ST_OUT: begin
        if (row_ready_i) begin
          if (row_q == LAST_ROW) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d      = row_q + ROW_W'(1);
            row_addr_d = row_addr_q + ADDR_W'(ROW_STRIDE);
            word_d     = '0;
            state_d    = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_rd_o    = (state_q == ST_REQ);
  assign mem_addr_o  = row_addr_q + ADDR_W'(word_q);
  assign row_data_o  = data_q;
  assign row_valid_o = (state_q == ST_OUT);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Bench for ref_row_fetcher: a 23-row and a 1-row instance, a latency-randomised memory responder
// and a window-level reference model that predicts every read address and every delivered row.
module tb_ref_row_fetcher;

  logic              clk;
  logic              rst;
  logic [15:0]       base;
  logic [1:0]        start;
  logic [1:0]        ready;
  logic [1:0]        rvalid;
  logic [1:0][63:0]  rdata;
  wire  [1:0]        mem_rd;
  wire  [1:0][15:0]  mem_addr;
  wire  [1:0][183:0] row_data;
  wire  [1:0]        row_valid;
  wire  [1:0]        busy;
  wire  [1:0]        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int ready_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit spur_en = 1'b0;
  logic [63:0] salt = '0;

  // window-level model state
  logic [15:0]  exp_addr_q[$];
  logic [183:0] exp_row_q[$];
  logic [15:0]  rd_log[$];
  int           nrows[2] = '{23, 1};
  bit           act[2];
  bit           done_next[2];
  bit           have_last[2];
  logic [183:0] last_row[2];
  int           rows_left[2];
  int           done_cnt[2], rv_cnt[2], reads_cnt[2], hs_cnt[2];
  // memory responder state
  bit           pend[2];
  int           pcnt[2];
  logic [15:0]  paddr[2];
  logic [15:0]  ma;
  logic [63:0]  w0, w1, w2;
  bit           cur_done, was_act;

  ref_row_fetcher #(.ADDR_W(16), .NUM_ROWS(23), .ROW_STRIDE(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .base_addr_i(base),
    .mem_rd_o(mem_rd[0]), .mem_addr_o(mem_addr[0]), .mem_rdata_i(rdata[0]),
    .mem_rvalid_i(rvalid[0]), .row_data_o(row_data[0]), .row_valid_o(row_valid[0]),
    .row_ready_i(ready[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  ref_row_fetcher #(.ADDR_W(16), .NUM_ROWS(1), .ROW_STRIDE(4)) u_one (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .base_addr_i(base),
    .mem_rd_o(mem_rd[1]), .mem_addr_o(mem_addr[1]), .mem_rdata_i(rdata[1]),
    .mem_rvalid_i(rvalid[1]), .row_data_o(row_data[1]), .row_valid_o(row_valid[1]),
    .row_ready_i(ready[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // memory contents: byte p of word a = 8*(a-0x10)+p, XORed with a per-test salt
  function automatic logic [63:0] mem_word(input logic [15:0] a, input logic [63:0] s);
    logic [63:0] w;
    logic [15:0] off;
    off = a - 16'h0010;
    for (int p = 0; p < 8; p++) w[8*p +: 8] = 8'(off * 8 + p);
    return w ^ s;
  endfunction

  task automatic chk(input string name, input int inst, input logic [183:0] got,
                     input logic [183:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%h exp=%h", name, inst, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int i, input logic [15:0] b);
    base     = b;
    start[i] = 1'b1;
    t_start  = cyc;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      tick();
      n++;
    end
    chk("done_wait", i, done[i], 1);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    ready = 2'b11;
    forever begin
      tick();
      case (ready_mode)
        0:       ready = 2'b11;
        1:       ready = 2'($urandom_range(3, 0));
        default: ready = 2'b00;
      endcase
    end
  end

  // ---------------- scoreboard + memory responder ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 0; done_next[i] = 0; have_last[i] = 0; rows_left[i] = 0;
      end else begin
        cur_done = done_next[i];
        was_act  = act[i];
        done_next[i] = 0;
        if (done[i]) done_cnt[i]++;
        if (row_valid[i]) rv_cnt[i]++;
        chk("busy_o", i, busy[i], was_act);
        chk("done_o", i, done[i], cur_done);
        if (mem_rd[i]) begin
          reads_cnt[i]++;
          rd_log.push_back(mem_addr[i]);
          chk("rd_during_out", i, row_valid[i], 0);
          chk("rd_outstanding", i, pend[i], 0);
          if (exp_addr_q.size() == 0) chk("rd_unexpected", i, mem_rd[i], 0);
          else chk("rd_addr", i, mem_addr[i], exp_addr_q.pop_front());
        end
        if (!was_act) begin
          chk("idle_row_valid", i, row_valid[i], 0);
          chk("idle_mem_rd", i, mem_rd[i], 0);
          chk("idle_row_data", i, row_data[i], have_last[i] ? last_row[i] : '0);
        end else if (row_valid[i]) begin
          if (exp_row_q.size() == 0) chk("row_unexpected", i, row_valid[i], 0);
          else begin
            chk("row_data", i, row_data[i], exp_row_q[0]);
            if (ready[i]) begin
              last_row[i]  = exp_row_q.pop_front();
              have_last[i] = 1;
              hs_cnt[i]++;
              rows_left[i]--;
              if (rows_left[i] == 0) begin
                act[i] = 0;
                done_next[i] = 1;
              end
            end
          end
        end
        if (start[i] && !was_act && !cur_done) begin
          act[i] = 1;
          rows_left[i] = nrows[i];
          for (int r = 0; r < nrows[i]; r++) begin
            ma = 16'(base + r * 4);
            w0 = mem_word(ma, salt);
            exp_addr_q.push_back(ma);
            ma = ma + 16'd1;
            w1 = mem_word(ma, salt);
            exp_addr_q.push_back(ma);
            ma = ma + 16'd1;
            w2 = mem_word(ma, salt);
            exp_addr_q.push_back(ma);
            exp_row_q.push_back({w2[55:0], w1, w0});
          end
        end
      end
    end
    if (rst) begin
      exp_addr_q.delete();
      exp_row_q.delete();
    end
    // responder: in-order, one outstanding, latency lat_min..lat_max; optional stray rvalid
    for (int i = 0; i < 2; i++) begin
      rvalid[i] = 1'b0;
      if (pend[i]) begin
        pcnt[i]--;
        if (pcnt[i] == 0) begin
          rvalid[i] = 1'b1;
          rdata[i]  = mem_word(paddr[i], salt);
          pend[i]   = 0;
        end
      end else if (!mem_rd[i] && spur_en && $urandom_range(3, 0) == 0) begin
        rvalid[i] = 1'b1;
        rdata[i]  = {$urandom, $urandom};
      end
      if (mem_rd[i]) begin
        pend[i]  = 1;
        pcnt[i]  = $urandom_range(lat_max, lat_min);
        paddr[i] = mem_addr[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rd_before;
    rst = 1'b1; base = '0; rvalid = '0; rdata = '0;
    // reset held two cycles with start asserted
    start = 2'b11;
    repeat (2) tick();
    start = 2'b00;
    rst   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_row_valid", i, row_valid[i], 0);
      chk("rst_mem_rd", i, mem_rd[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_row_data", i, row_data[i], '0);
      chk("rst_mem_addr", i, mem_addr[i], '0);
    end
    tick();

    // single-row instance, base 0x0010, 1-cycle memory
    salt = '0; lat_min = 1; lat_max = 1; ready_mode = 0;
    rd_log.delete();
    start_cmd(1, 16'h0010);
    wait_done(1, 100);
    chk("single_latency", 1, cyc - t_start, 8);
    repeat (2) tick();
    chk("single_valid_cycles", 1, rv_cnt[1], 1);
    chk("single_done_cnt", 1, done_cnt[1], 1);
    chk("single_row_lit", 1, row_data[1],
        184'h161514131211100f0e0d0c0b0a09080706050403020100);
    chk("single_nreads", 1, rd_log.size(), 3);
    chk("single_rd0", 1, rd_log[0], 16'h0010);
    chk("single_rd1", 1, rd_log[1], 16'h0011);
    chk("single_rd2", 1, rd_log[2], 16'h0012);

    // full window at 0x0100, plus a start pulse in the done cycle that must be ignored
    salt = {$urandom, $urandom};
    rd_log.delete();
    reads_cnt[0] = 0; hs_cnt[0] = 0; done_cnt[0] = 0;
    start_cmd(0, 16'h0100);
    wait_done(0, 1000);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    chk("full_reads", 0, reads_cnt[0], 69);
    chk("full_rows", 0, hs_cnt[0], 23);
    chk("full_dones", 0, done_cnt[0], 1);
    chk("full_busy_after", 0, busy[0], 0);
    chk("full_rd3", 0, rd_log[3], 16'h0104);
    chk("full_rd68", 0, rd_log[68], 16'h015A);

    // backpressure: ready low 10 cycles in OUT, with stray rvalid pulses
    salt = {$urandom, $urandom};
    lat_min = 1; lat_max = 3; ready_mode = 2;
    start_cmd(0, 16'($urandom));
    n = 0;
    while (!row_valid[0] && n < 100) begin
      tick();
      n++;
    end
    chk("bp_valid_wait", 0, row_valid[0], 1);
    rd_before = reads_cnt[0];
    spur_en = 1'b1;
    repeat (10) tick();
    chk("bp_valid_held", 0, row_valid[0], 1);
    chk("bp_no_reads", 0, reads_cnt[0], rd_before);
    ready_mode = 1;
    wait_done(0, 4000);
    spur_en = 1'b0;
    tick();

    // address wrap with random memory latency
    salt = {$urandom, $urandom};
    lat_min = 1; lat_max = 5;
    rd_log.delete();
    start_cmd(0, 16'hFFFE);
    wait_done(0, 5000);
    chk("wrap_rd0", 0, rd_log[0], 16'hFFFE);
    chk("wrap_rd1", 0, rd_log[1], 16'hFFFF);
    chk("wrap_rd2", 0, rd_log[2], 16'h0000);
    chk("wrap_rd3", 0, rd_log[3], 16'h0002);
    ready_mode = 0;
    tick();

    // reset during WAIT of row 5; the late rvalid must be ignored
    salt = {$urandom, $urandom};
    lat_min = 4; lat_max = 5;
    hs_cnt[0] = 0;
    start_cmd(0, 16'($urandom));
    n = 0;
    while (!(hs_cnt[0] == 5 && pend[0]) && n < 500) begin
      tick();
      n++;
    end
    chk("rst_wait_reached", 0, hs_cnt[0], 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("abort_row_valid", 0, row_valid[0], 0);
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_row_data", 0, row_data[0], '0);
    lat_min = 1; lat_max = 2;
    hs_cnt[0] = 0;
    start_cmd(0, 16'($urandom));
    wait_done(0, 3000);
    chk("restart_rows", 0, hs_cnt[0], 23);
    tick();

    // random windows on both instances
    for (int k = 0; k < 4; k++) begin
      salt = {$urandom, $urandom};
      lat_min = 1; lat_max = $urandom_range(5, 1);
      ready_mode = 1; spur_en = 1'b1;
      start_cmd(k % 2, 16'($urandom));
      wait_done(k % 2, 6000);
      ready_mode = 0; spur_en = 1'b0;
      repeat (3) tick();
    end

    repeat (5) tick();
    chk("left_addrs", 0, exp_addr_q.size(), 0);
    chk("left_rows", 0, exp_row_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
